clb_config_loader: RTL

Serial configuration controller for an array of NUM_CLB CLBs. Each CLB takes an 18-bit SRAM configuration word. The block receives a bitstream over a valid/ready handshake, checks per-word even parity, writes each word into its CLB slot, and holds the CLB array disabled until the full configuration has loaded cleanly. It sits between the external config port and the sram_data inputs of the CLB instances.

---
 rtl/clb_config_loader_if.sv | 22 ++
 rtl/clb_config_loader.sv | 94 +++++++++
 2 files changed

// File: rtl/clb_config_loader_if.sv
// Config port handshake bundle for clb_config_loader.
// master drives start/valid/bit, slave returns ready.
interface clb_config_loader_if;
    logic cfg_start;
    logic cfg_valid;
    logic cfg_bit;
    logic cfg_ready;

    modport master (
        output cfg_start,
        output cfg_valid,
        output cfg_bit,
        input  cfg_ready
    );

    modport slave (
        input  cfg_start,
        input  cfg_valid,
        input  cfg_bit,
        output cfg_ready
    );
endinterface

// File: rtl/clb_config_loader.sv
// Serial CLB config loader: 19-bit even-parity frames into NUM_CLB slots.
// Ports: clk, res (async low), cfg (slave if), busy/done/err/clb_en, sram_bus.
module clb_config_loader #(
    parameter int NUM_CLB = 4,
    parameter int CFG_W   = 18
) (
    input  logic                     clk,
    input  logic                     res,
    clb_config_loader_if.slave       cfg,
    output logic                     cfg_busy,
    output logic                     cfg_done,
    output logic                     cfg_err,
    output logic                     clb_en,
    output logic [NUM_CLB*CFG_W-1:0] sram_bus
);

    localparam int FW  = CFG_W + 1;
    localparam int BW  = $clog2(FW + 1);
    localparam int WCW = (NUM_CLB > 1) ? $clog2(NUM_CLB) : 1;

    localparam logic [BW-1:0]  LAST_BIT  = BW'(FW - 1);
    localparam logic [WCW-1:0] LAST_WORD = WCW'(NUM_CLB - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_COMMIT = 3'd2;
    localparam logic [2:0] S_DONE   = 3'd3;
    localparam logic [2:0] S_ERROR  = 3'd4;

    logic [2:0]               state;
    logic [FW-1:0]            shreg;
    logic [BW-1:0]            bit_cnt;
    logic [WCW-1:0]           word_cnt;
    logic [NUM_CLB*CFG_W-1:0] sram_q;
    logic                     par_ok;

    // Even parity over data plus parity bit.
    assign par_ok = ~(^shreg);

    // All status outputs decode straight from state so that
    // an asynchronous reset clears them without a clock edge.
    assign cfg.cfg_ready = (state == S_LOAD);
    assign cfg_busy      = (state == S_LOAD) || (state == S_COMMIT);
    assign cfg_done      = (state == S_DONE);
    assign clb_en        = (state == S_DONE);
    assign cfg_err       = (state == S_ERROR);
    assign sram_bus      = sram_q;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state    <= S_IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            sram_q   <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (cfg.cfg_valid) begin
                        shreg <= {shreg[FW-2:0], cfg.cfg_bit};
                        if (bit_cnt == LAST_BIT) begin
                            state <= S_COMMIT;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                S_COMMIT: begin
                    if (par_ok) begin
                        sram_q[word_cnt*CFG_W +: CFG_W] <= shreg[FW-1:1];
                        if (word_cnt == LAST_WORD) begin
                            state <= S_DONE;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                            bit_cnt  <= '0;
                            state    <= S_LOAD;
                        end
                    end else begin
                        state <= S_ERROR;
                    end
                end
                S_IDLE, S_DONE, S_ERROR: begin
                    if (cfg.cfg_start) begin
                        state    <= S_LOAD;
                        bit_cnt  <= '0;
                        word_cnt <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
